// File: rtl/timekeeper_adj_p_pkg.sv
// Shared types and helpers for the digital-clock timekeeper.
// BCD limits, FSM states and 24h->12h hour conversion.
package clock_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] digit_t;

    localparam digit_t     SEP_DEFAULT = 4'hA;
    localparam logic [7:0] HOUR_MAX    = 8'h23;
    localparam logic [7:0] MIN_MAX     = 8'h59;

    // Returns {pm, hour12_bcd}; midnight shows as 12.
    function automatic logic [8:0] bcd_to_12h(input logic [7:0] hour_bcd);
        logic [4:0] bin;
        logic [4:0] h12;
        logic       pm_f;
        bin  = 5'(hour_bcd[7:4]) * 5'd10 + 5'(hour_bcd[3:0]);
        pm_f = (bin >= 5'd12);
        if (bin == 5'd0)
            h12 = 5'd12;
        else if (bin > 5'd12)
            h12 = bin - 5'd12;
        else
            h12 = bin;
        if (h12 >= 5'd10)
            return {pm_f, 4'd1, 4'(h12 - 5'd10)};
        return {pm_f, 4'd0, h12[3:0]};
    endfunction

endpackage

// File: rtl/timekeeper_adj_p_if.sv
// Button strobes and time/display outputs of the timekeeper.
// master = button/display side, slave = timekeeper.
interface timekeeper_adj_p_if;

    logic        mode_en;
    logic        disp_switch_p;
    logic        set_hour_p;
    logic        set_min_p;
    logic        confirm_p;
    logic        fmt_toggle_p;
    logic [23:0] cnt_bcd;
    logic [31:0] data_disp;
    logic        disp_mode;
    logic        fmt_12h;
    logic        pm;
    logic        sec_tick;

    modport master (
        output mode_en, disp_switch_p, set_hour_p,
        output set_min_p, confirm_p, fmt_toggle_p,
        input  cnt_bcd, data_disp, disp_mode,
        input  fmt_12h, pm, sec_tick
    );

    modport slave (
        input  mode_en, disp_switch_p, set_hour_p,
        input  set_min_p, confirm_p, fmt_toggle_p,
        output cnt_bcd, data_disp, disp_mode,
        output fmt_12h, pm, sec_tick
    );

endinterface

// File: rtl/timekeeper_adj_p_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX_BCD.
// Load has priority over increment; carry_out fires on wrap.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = MIN_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry_out
);

    logic       wrap;
    logic [7:0] nxt;

    assign wrap      = (value == MAX_BCD);
    assign carry_out = inc & wrap;

    // Next value: load, else BCD increment with wrap
    always_comb begin
        nxt = value;
        if (load)
            nxt = load_val;
        else if (inc) begin
            if (wrap)
                nxt = 8'h00;
            else if (value[3:0] == 4'd9)
                nxt = {value[7:4] + 4'd1, 4'd0};
            else
                nxt = value + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= 8'h00;
        else
            value <= nxt;
    end

endmodule

// File: rtl/timekeeper_adj_p.sv
// HH:MM:SS BCD timekeeper with live hour/minute preload editing.
// Display word in 24h or 12h; cnt_bcd is always 24h.
module timekeeper_adj_p
    import clock_pkg::*;
#(
    parameter int     CLK_FREQ = 50_000_000,
    parameter int     TICK_HZ  = 1,
    parameter digit_t SEP_CODE = SEP_DEFAULT,
    parameter bit     EN_12H   = 1'b1
) (
    input  logic               sys_clk,
    input  logic               rst,
    timekeeper_adj_p_if.slave  bus
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TOP = PW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("timekeeper_adj_p: CLK_FREQ/TICK_HZ must be >= 2");
    end

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic          tick;
    logic          in_edit;
    logic          enter;
    logic          commit;
    logic          pre_inc_h;
    logic          pre_inc_m;
    logic [7:0]    sec;
    logic [7:0]    min;
    logic [7:0]    hour;
    logic [7:0]    min_pre;
    logic [7:0]    hour_pre;
    logic          sec_carry;
    logic          min_carry;
    logic          carry_unused_hour;
    logic          carry_unused_mpre;
    logic          carry_unused_hpre;
    logic          fmt;
    logic [31:0]   disp;
    logic          pm_now;
    logic [7:0]    hour_12;
    logic          pm_pre_unused;
    logic [7:0]    hour_pre_12;
    logic [7:0]    h_show;
    logic [7:0]    hp_show;

    assign in_edit   = (state == ST_EDIT);
    assign enter     = ~in_edit & bus.mode_en & bus.disp_switch_p;
    assign commit    = in_edit & bus.mode_en & bus.confirm_p;
    assign pre_inc_h = in_edit & bus.mode_en & ~bus.confirm_p & bus.set_hour_p;
    assign pre_inc_m = in_edit & bus.mode_en & ~bus.confirm_p & bus.set_min_p;
    assign tick      = (presc == TOP);

    // Prescaler: free running, realigned when a new time is committed
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (commit || tick)
            presc <= '0;
        else
            presc <= presc + PW'(1);
    end

    bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_sec (
        .clk(sys_clk), .rst(rst), .inc(tick), .load(commit),
        .load_val(8'h00), .value(sec), .carry_out(sec_carry)
    );

    bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
        .clk(sys_clk), .rst(rst), .inc(sec_carry), .load(commit),
        .load_val(min_pre), .value(min), .carry_out(min_carry)
    );

    bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hour (
        .clk(sys_clk), .rst(rst), .inc(min_carry), .load(commit),
        .load_val(hour_pre), .value(hour), .carry_out(carry_unused_hour)
    );

    bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min_pre (
        .clk(sys_clk), .rst(rst), .inc(pre_inc_m), .load(enter),
        .load_val(min), .value(min_pre), .carry_out(carry_unused_mpre)
    );

    bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hour_pre (
        .clk(sys_clk), .rst(rst), .inc(pre_inc_h), .load(enter),
        .load_val(hour), .value(hour_pre), .carry_out(carry_unused_hpre)
    );

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // Next state: losing mode_en, confirm or switch all leave EDIT
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (enter)
                    state_nxt = ST_EDIT;
            end
            ST_EDIT: begin
                if (!bus.mode_en || bus.confirm_p || bus.disp_switch_p)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Display format flag, toggled only while running
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            fmt <= 1'b0;
        else if (EN_12H && !in_edit && bus.mode_en && bus.fmt_toggle_p)
            fmt <= ~fmt;
    end

    assign {pm_now, hour_12}             = bcd_to_12h(hour);
    assign {pm_pre_unused, hour_pre_12}  = bcd_to_12h(hour_pre);
    assign h_show  = fmt ? hour_12 : hour;
    assign hp_show = fmt ? hour_pre_12 : hour_pre;

    // Registered display word: live time or preload with blank seconds
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            disp <= {8'h00, SEP_CODE, 8'h00, SEP_CODE, 8'h00};
        else if (in_edit)
            disp <= {hp_show, SEP_CODE, min_pre, SEP_CODE, 8'h00};
        else
            disp <= {h_show, SEP_CODE, min, SEP_CODE, sec};
    end

    assign bus.cnt_bcd   = {hour, min, sec};
    assign bus.data_disp = disp;
    assign bus.disp_mode = in_edit;
    assign bus.fmt_12h   = fmt;
    assign bus.pm        = pm_now;
    assign bus.sec_tick  = tick;

endmodule

// File: tb/tb_timekeeper_adj_p.sv
// Scoreboard bench for timekeeper_adj_p at DIV=10.
// Second instance with EN_12H=0 shares all stimulus.
module tb_timekeeper_adj_p;

    localparam logic [4:0] P_SW  = 5'b00001;
    localparam logic [4:0] P_H   = 5'b00010;
    localparam logic [4:0] P_M   = 5'b00100;
    localparam logic [4:0] P_HM  = 5'b00110;
    localparam logic [4:0] P_CF  = 5'b01000;
    localparam logic [4:0] P_CFH = 5'b01010;
    localparam logic [4:0] P_FMT = 5'b10000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    timekeeper_adj_p_if bus();
    timekeeper_adj_p_if bus2();

    timekeeper_adj_p #(
        .CLK_FREQ(10), .TICK_HZ(1), .SEP_CODE(4'hA), .EN_12H(1'b1)
    ) dut (
        .sys_clk(clk), .rst(rst), .bus(bus)
    );

    timekeeper_adj_p #(
        .CLK_FREQ(10), .TICK_HZ(1), .SEP_CODE(4'hA), .EN_12H(1'b0)
    ) dut_24 (
        .sys_clk(clk), .rst(rst), .bus(bus2)
    );

    assign bus2.mode_en       = bus.mode_en;
    assign bus2.disp_switch_p = bus.disp_switch_p;
    assign bus2.set_hour_p    = bus.set_hour_p;
    assign bus2.set_min_p     = bus.set_min_p;
    assign bus2.confirm_p     = bus.confirm_p;
    assign bus2.fmt_toggle_p  = bus.fmt_toggle_p;

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        q.push_back('{tag, v});
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        if (q.size() == 0) begin
            chk("sb_empty", 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic pulse(input logic [4:0] m);
        @(negedge clk);
        {bus.fmt_toggle_p, bus.confirm_p, bus.set_min_p,
         bus.set_hour_p, bus.disp_switch_p} = m;
        @(negedge clk);
        {bus.fmt_toggle_p, bus.confirm_p, bus.set_min_p,
         bus.set_hour_p, bus.disp_switch_p} = '0;
    endtask

    task automatic presses(input logic [4:0] m, input int n);
        repeat (n) pulse(m);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sec_tick && n < 40);
        if (!bus.sec_tick)
            chk("tick_timeout", {31'b0, bus.sec_tick}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not end, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int last;
        int per_obs;
        int n;

        bus.mode_en = 1'b1;
        {bus.fmt_toggle_p, bus.confirm_p, bus.set_min_p,
         bus.set_hour_p, bus.disp_switch_p} = '0;

        // 1: reset values, free run for 600 cycles
        #2 rst = 1'b1;
        #1;
        push("rst_cnt", 32'h0);
        push("rst_mode", 32'h0);
        push("rst_fmt", 32'h0);
        push("rst_pm", 32'h0);
        push("rst_tick", 32'h0);
        pop({8'h0, bus.cnt_bcd});
        pop({31'b0, bus.disp_mode});
        pop({31'b0, bus.fmt_12h});
        pop({31'b0, bus.pm});
        pop({31'b0, bus.sec_tick});
        @(negedge clk);
        rst = 1'b0;

        push("t1_ticks", 32'd60);
        push("t1_period", 32'd10);
        push("t1_cnt", 32'h000100);
        push("t1_disp", 32'h00A01A00);
        ticks   = 0;
        last    = -1;
        per_obs = 0;
        for (int k = 1; k <= 601; k++) begin
            @(negedge clk);
            if (bus.sec_tick) begin
                ticks++;
                if (last >= 0 && (per_obs == 0 || k - last != 10))
                    per_obs = k - last;
                last = k;
            end
        end
        pop(32'(ticks));
        pop(32'(per_obs));
        pop({8'h0, bus.cnt_bcd});
        pop(bus.data_disp);

        // 2: 23:59:59 rollover, both set strobes together
        do_reset();
        pulse(P_SW);
        presses(P_HM, 23);
        presses(P_M, 36);
        push("t2_edit_disp", 32'h23A59A00);
        push("t2_edit_mode", 32'h1);
        @(negedge clk);
        pop(bus.data_disp);
        pop({31'b0, bus.disp_mode});
        pulse(P_CF);
        push("t2_load", 32'h235900);
        push("t2_pm", 32'h1);
        pop({8'h0, bus.cnt_bcd});
        pop({31'b0, bus.pm});
        repeat (59) wait_tick();
        @(negedge clk);
        push("t2_last", 32'h235959);
        pop({8'h0, bus.cnt_bcd});
        wait_tick();
        @(negedge clk);
        push("t2_wrap", 32'h000000);
        push("t2_pm_clr", 32'h0);
        pop({8'h0, bus.cnt_bcd});
        pop({31'b0, bus.pm});

        // 3: edit from 10:20 to 13:05, next tick alignment
        do_reset();
        pulse(P_SW);
        presses(P_H, 10);
        presses(P_M, 20);
        pulse(P_CF);
        pulse(P_SW);
        presses(P_H, 3);
        presses(P_M, 45);
        pulse(P_CF);
        push("t3_cnt", 32'h130500);
        push("t3_mode", 32'h0);
        pop({8'h0, bus.cnt_bcd});
        pop({31'b0, bus.disp_mode});
        @(negedge clk);
        push("t3_disp", 32'h13A05A00);
        pop(bus.data_disp);
        push("t3_latency", 32'd10);
        n = 1;
        while (bus.cnt_bcd[7:0] == 8'h00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        pop(32'(n));

        // 4: preload wraps, cancel leaves time alone
        do_reset();
        pulse(P_SW);
        presses(P_H, 23);
        @(negedge clk);
        push("t4_h23", 32'h23A00A00);
        pop(bus.data_disp);
        pulse(P_H);
        @(negedge clk);
        push("t4_hwrap", 32'h00A00A00);
        pop(bus.data_disp);
        presses(P_M, 59);
        @(negedge clk);
        push("t4_m59", 32'h00A59A00);
        pop(bus.data_disp);
        pulse(P_M);
        @(negedge clk);
        push("t4_mwrap", 32'h00A00A00);
        pop(bus.data_disp);
        presses(P_H, 5);
        pulse(P_SW);
        push("t4_mode", 32'h0);
        push("t4_keep", 32'h0000);
        pop({31'b0, bus.disp_mode});
        pop({16'h0, bus.cnt_bcd[23:8]});
        @(negedge clk);
        push("t4_disp_h", 32'h00);
        pop({24'h0, bus.data_disp[31:24]});

        // 5: 12h display, EN_12H=0 instance ignores toggle
        do_reset();
        pulse(P_SW);
        presses(P_M, 30);
        pulse(P_CF);
        pulse(P_FMT);
        @(negedge clk);
        push("t5_disp12", 32'h12A30A00);
        push("t5_fmt", 32'h1);
        push("t5_pm", 32'h0);
        push("t5_cnt", 32'h003000);
        push("t5_fmt_off", 32'h0);
        push("t5_disp24", 32'h00A30A00);
        pop(bus.data_disp);
        pop({31'b0, bus.fmt_12h});
        pop({31'b0, bus.pm});
        pop({8'h0, bus.cnt_bcd});
        pop({31'b0, bus2.fmt_12h});
        pop(bus2.data_disp);
        pulse(P_SW);
        presses(P_H, 13);
        presses(P_M, 30);
        @(negedge clk);
        push("t5_edit12", 32'h01A00A00);
        push("t5_edit24", 32'h13A00A00);
        pop(bus.data_disp);
        pop(bus2.data_disp);
        pulse(P_FMT);
        pulse(P_CF);
        @(negedge clk);
        push("t5_cnt13", 32'h130000);
        push("t5_pm13", 32'h1);
        push("t5_fmt_kept", 32'h1);
        push("t5_disp13", 32'h01A00A00);
        push("t5_disp13_24", 32'h13A00A00);
        push("t5_pm13_24", 32'h1);
        pop({8'h0, bus.cnt_bcd});
        pop({31'b0, bus.pm});
        pop({31'b0, bus.fmt_12h});
        pop(bus.data_disp);
        pop(bus2.data_disp);
        pop({31'b0, bus2.pm});

        // 6: confirm priority, mode_en drop, async reset
        pulse(P_SW);
        presses(P_H, 2);
        pulse(P_CFH);
        push("t6_cf_wins", 32'h1500);
        push("t6_cf_mode", 32'h0);
        pop({16'h0, bus.cnt_bcd[23:8]});
        pop({31'b0, bus.disp_mode});
        pulse(P_SW);
        pulse(P_H);
        @(negedge clk);
        bus.mode_en = 1'b0;
        @(negedge clk);
        push("t6_drop_mode", 32'h0);
        pop({31'b0, bus.disp_mode});
        bus.mode_en = 1'b1;
        pulse(P_CF);
        push("t6_no_load", 32'h1500);
        pop({16'h0, bus.cnt_bcd[23:8]});
        bus.mode_en = 1'b0;
        pulse(P_SW);
        push("t6_gated_sw", 32'h0);
        pop({31'b0, bus.disp_mode});
        bus.mode_en = 1'b1;
        pulse(P_SW);
        pulse(P_H);
        push("t6_in_edit", 32'h1);
        pop({31'b0, bus.disp_mode});
        #2 rst = 1'b1;
        #1;
        push("t6_rst_cnt", 32'h0);
        push("t6_rst_mode", 32'h0);
        push("t6_rst_fmt", 32'h0);
        push("t6_rst_pm", 32'h0);
        push("t6_rst_tick", 32'h0);
        pop({8'h0, bus.cnt_bcd});
        pop({31'b0, bus.disp_mode});
        pop({31'b0, bus.fmt_12h});
        pop({31'b0, bus.pm});
        pop({31'b0, bus.sec_tick});
        @(negedge clk);
        rst = 1'b0;

        chk("sb_left", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
